// File: rtl/pipelined_control_unit.sv
// Decode stage control unit: registers decoded control into ID/EX, tracks the
// destination of the last LDD and stalls dependent instructions for LOAD_LAT cycles.
module pipelined_control_unit #(
  parameter int unsigned INST_W    = 16,
  parameter int unsigned REG_AW    = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst_i,
  input  logic              inst_valid_i,
  input  logic              flush_i,
  input  logic              illegal_clr_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_wb_alu_to_reg_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic [1:0]        ex_alu_op_o,
  output logic [REG_AW-1:0] ex_rdst_o,
  output logic [REG_AW-1:0] ex_rsrc_o,
  output logic              illegal_o
);

  localparam logic [2:0] OpLdm = 3'b001;
  localparam logic [2:0] OpStd = 3'b010;
  localparam logic [2:0] OpAdd = 3'b011;
  localparam logic [2:0] OpNot = 3'b100;
  localparam logic [2:0] OpNop = 3'b101;
  localparam logic [2:0] OpLdd = 3'b110;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  logic [2:0]        op;
  logic [REG_AW-1:0] rdst, rsrc;
  logic [5:0]        ctl_dec;  // {wb_alu_to_reg, reg_write, mem_read, mem_write, alu_op}
  logic              reads_rdst, reads_rsrc, legal;
  logic              hazard, issue;
  logic              unused_inst;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              ex_valid_q, ex_valid_d;
  logic [5:0]        ex_ctl_q, ex_ctl_d;
  logic [REG_AW-1:0] ex_rdst_q, ex_rdst_d, ex_rsrc_q, ex_rsrc_d;
  logic              illegal_q, illegal_d;

  assign op          = inst_i[INST_W-1 -: 3];
  assign rdst        = inst_i[INST_W-4 -: REG_AW];
  assign rsrc        = inst_i[INST_W-4-REG_AW -: REG_AW];
  assign unused_inst = ^inst_i[INST_W-4-2*REG_AW:0];

  always_comb begin
    ctl_dec    = 6'b0;
    reads_rdst = 1'b0;
    reads_rsrc = 1'b0;
    legal      = 1'b1;
    case (op)
      OpLdm: ctl_dec = 6'b0100_11;
      OpStd: begin
        ctl_dec    = 6'b0001_10;
        reads_rdst = 1'b1;
        reads_rsrc = 1'b1;
      end
      OpAdd: begin
        ctl_dec    = 6'b1100_00;
        reads_rdst = 1'b1;
        reads_rsrc = 1'b1;
      end
      OpNot: begin
        ctl_dec    = 6'b1100_01;
        reads_rdst = 1'b1;
      end
      OpNop: ctl_dec = 6'b0000_11;
      OpLdd: begin
        ctl_dec    = 6'b0110_10;
        reads_rsrc = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign hazard  = (state_q == StPending) &&
                   ((reads_rdst && (rdst == pend_rd_q)) || (reads_rsrc && (rsrc == pend_rd_q)));
  assign stall_o = (HAZARD_EN != 0) && inst_valid_i && !flush_i && hazard;
  assign issue   = inst_valid_i && !flush_i && !stall_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = 2'd0;
    end else if (issue && (op == OpLdd)) begin
      state_d   = StPending;
      cnt_d     = 2'(LOAD_LAT);
      pend_rd_d = rdst;
    end else if (state_q == StPending) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = StIdle;
    end
  end

  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctl_d   = 6'b0;
    ex_rdst_d  = '0;
    ex_rsrc_d  = '0;
    if (issue && legal) begin
      ex_valid_d = 1'b1;
      ex_ctl_d   = ctl_dec;
      ex_rdst_d  = rdst;
      ex_rsrc_d  = rsrc;
    end
    // A new illegal opcode outranks a same-cycle clear.
    illegal_d = (issue && !legal) || (illegal_q && !illegal_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      pend_rd_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_ctl_q   <= 6'b0;
      ex_rdst_q  <= '0;
      ex_rsrc_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_rd_q  <= pend_rd_d;
      ex_valid_q <= ex_valid_d;
      ex_ctl_q   <= ex_ctl_d;
      ex_rdst_q  <= ex_rdst_d;
      ex_rsrc_q  <= ex_rsrc_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid_o         = ex_valid_q;
  assign ex_wb_alu_to_reg_o = ex_ctl_q[5];
  assign ex_reg_write_o     = ex_ctl_q[4];
  assign ex_mem_read_o      = ex_ctl_q[3];
  assign ex_mem_write_o     = ex_ctl_q[2];
  assign ex_alu_op_o        = ex_ctl_q[1:0];
  assign ex_rdst_o          = ex_rdst_q;
  assign ex_rsrc_o          = ex_rsrc_q;
  assign illegal_o          = illegal_q;

endmodule
